// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through byte FIFO controller driving a 1-cycle-latency dual-port SRAM.
// Optional almost_full output and AF_THRESH parameter under `SRAM_FIFO_ALMOST_FULL_EN.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
`ifdef SRAM_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  overflow,
    input  logic                  ovf_clr,
`ifdef SRAM_FIFO_ALMOST_FULL_EN
    output logic                  almost_full,
`endif
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_count_q, ram_count_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]            out_occ_q, out_occ_d, occ_sum;
    logic                  fetch_pending_q, fetch_pending_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc, pop, push, fetch;

    always_comb begin
        // ram_count never exceeds DEPTH, so its MSB alone marks full.
        wr_ready = !rst && !ram_count_q[ADDR_WIDTH];
        wr_acc   = wr_valid && wr_ready && !flush;
        rd_valid = (out_occ_q != 2'd0);
        pop      = rd_valid && rd_ready;
        push     = fetch_pending_q && !flush;
        occ_sum  = out_occ_q + {1'b0, fetch_pending_q};
        // A pop frees a slot this cycle, letting a fetch go out to keep 1 word/clk.
        fetch    = !flush && (ram_count_q != '0) && ((occ_sum < 2'd2) || pop);

        ram_we_a   = wr_acc;
        ram_addr_a = wr_ptr_q;
        ram_data_a = wr_data;
        ram_we_b   = 1'b0;
        ram_addr_b = rd_ptr_q;

        wr_ptr_d        = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d        = fetch  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        fetch_pending_d = fetch;
        ram_count_d     = ram_count_q;
        if (wr_acc && !fetch)
            ram_count_d = ram_count_q + CW'(1);
        else if (!wr_acc && fetch)
            ram_count_d = ram_count_q - CW'(1);

        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        out_occ_d = out_occ_q;
        if (push && pop) begin
            if (out_occ_q == 2'd2) begin
                ent0_d = ent1_q;
                ent1_d = ram_q_b;
            end else begin
                ent0_d = ram_q_b;
            end
        end else if (pop) begin
            ent0_d    = ent1_q;
            out_occ_d = out_occ_q - 2'd1;
        end else if (push) begin
            if (out_occ_q == 2'd0) ent0_d = ram_q_b;
            else                   ent1_d = ram_q_b;
            out_occ_d = out_occ_q + 2'd1;
        end

        if (flush) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            ram_count_d     = '0;
            out_occ_d       = '0;
            fetch_pending_d = 1'b0;
        end

        level_d    = {1'b0, ram_count_d} + {{ADDR_WIDTH{1'b0}}, out_occ_d}
                   + {{CW{1'b0}}, fetch_pending_d};
        overflow_d = (overflow_q && !ovf_clr) || (wr_valid && !wr_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            ram_count_q     <= '0;
            ent0_q          <= '0;
            ent1_q          <= '0;
            out_occ_q       <= '0;
            fetch_pending_q <= 1'b0;
            level_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            ram_count_q     <= ram_count_d;
            ent0_q          <= ent0_d;
            ent1_q          <= ent1_d;
            out_occ_q       <= out_occ_d;
            fetch_pending_q <= fetch_pending_d;
            level_q         <= level_d;
            overflow_q      <= overflow_d;
        end
    end

    assign rd_data  = ent0_q;
    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef SRAM_FIFO_ALMOST_FULL_EN
    localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
    logic almost_full_q, almost_full_d;

    always_comb almost_full_d = !flush && (level_d >= AF_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full_q <= 1'b0;
        else     almost_full_q <= almost_full_d;
    end

    assign almost_full = almost_full_q;
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomised bench for sram_fifo_ctrl: queue-based reference model plus a behavioural SRAM.
module tb_sram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0, ovf_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_valid, overflow, ram_we_a, ram_we_b;
    logic [DW-1:0] rd_data, ram_data_a, ram_q_b;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_addr_a, ram_addr_b;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic          last_acc, last_pop;
    logic [DW-1:0] last_data, last_exp;
    int            n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
    );

    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    // One clock: drive inputs at a negedge, record the handshakes, advance the model.
    task automatic tick(input logic wv, input logic [DW-1:0] wd, input logic rr);
        wr_valid = wv; wr_data = wd; rd_ready = rr;
        #1;
        last_acc  = wr_valid && wr_ready && !flush;
        last_pop  = rd_valid && rd_ready && !flush;
        last_data = rd_data;
        last_exp  = 'x;
        if (flush) exp_q.delete();
        if (last_pop && exp_q.size() > 0) last_exp = exp_q.pop_front();
        if (last_acc) exp_q.push_back(wd);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_hold rd_valid=%b level=%0d ovf=%b rd_data=%h want 0/0/0/00",
                     rd_valid, level, overflow, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || level !== '0 || ram_we_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle wr_ready=%b rd_valid=%b level=%0d we_b=%b want 1/0/0/0",
                     wr_ready, rd_valid, level, ram_we_b);
        end
    endtask

    task automatic test_single;
        tick(1'b1, 8'hA5, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL single_early rd_valid=%b want 0", rd_valid);
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== AW'(exp_q.size()) + 8'd0) begin
            n_err++;
            $display("FAIL single_show rd_valid=%b rd_data=%h level=%0d want 1/a5/%0d",
                     rd_valid, rd_data, level, exp_q.size());
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (last_pop !== 1'b1 || last_data !== last_exp) begin
            n_err++; $display("FAIL single_pop pop=%b data=%h want 1/%h", last_pop, last_data, last_exp);
        end
        n_cmp++;
        if (rd_valid !== 1'b0 || level !== 8'(exp_q.size())) begin
            n_err++; $display("FAIL single_after rd_valid=%b level=%0d want 0/%0d", rd_valid, level, exp_q.size());
        end
    endtask

    task automatic test_fill;
        int n = 0, got = 0;
        for (int c = 0; c < 300 && n < DEPTH + 2; c++) begin
            tick(1'b1, 8'(n), 1'b0);
            if (last_acc) n++;
        end
        n_cmp++;
        if (n != DEPTH + 2 || level !== 8'(exp_q.size()) || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full accepted=%0d level=%0d wr_ready=%b want %0d/%0d/0",
                     n, level, wr_ready, DEPTH + 2, exp_q.size());
        end
        tick(1'b1, 8'hEE, 1'b0);
        n_cmp++;
        if (last_acc !== 1'b0 || overflow !== 1'b1 || level !== 8'(DEPTH + 2)) begin
            n_err++;
            $display("FAIL fill_overflow acc=%b ovf=%b level=%0d want 0/1/%0d", last_acc, overflow, level, DEPTH + 2);
        end
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            tick(1'b0, 8'h00, 1'b1);
            if (last_pop) begin
                n_cmp++;
                if (last_data !== last_exp || last_data !== 8'(got)) begin
                    n_err++; $display("FAIL fill_drain idx=%0d got=%h want %h", got, last_data, got[7:0]);
                end
                got++;
            end
        end
        n_cmp++;
        if (got != DEPTH + 2 || rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL fill_drained words=%0d rd_valid=%b ovf=%b want %0d/0/1", got, rd_valid, overflow, DEPTH + 2);
        end
        ovf_clr = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr ovf=%b want 0", overflow);
        end
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            tick(1'b0, 8'h00, 1'b1);
            if (last_pop) begin
                n_cmp++;
                if (last_data !== last_exp) begin
                    n_err++; $display("FAIL %s_drain got=%h want %h", tag, last_data, last_exp);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || rd_valid !== 1'b0 || level !== '0) begin
            n_err++;
            $display("FAIL %s_empty left=%0d rd_valid=%b level=%0d want 0/0/0", tag, exp_q.size(), rd_valid, level);
        end
    endtask

    task automatic test_back_to_back;
        logic [AW+1:0] steady = '0;
        for (int k = 0; k < 200; k++) begin
            tick(1'b1, 8'(k + 17), 1'b1);
            n_cmp++;
            if (last_acc !== 1'b1 || level !== 8'(exp_q.size())) begin
                n_err++;
                $display("FAIL b2b_write k=%0d acc=%b level=%0d want 1/%0d", k, last_acc, level, exp_q.size());
            end
            if (k >= 3) begin
                if (k == 3) steady = level;
                n_cmp++;
                if (last_pop !== 1'b1 || last_data !== last_exp || level !== steady) begin
                    n_err++;
                    $display("FAIL b2b_read k=%0d pop=%b data=%h level=%0d want 1/%h/%0d",
                             k, last_pop, last_data, level, last_exp, steady);
                end
            end
        end
        drain("b2b");
    endtask

    task automatic test_random;
        for (int k = 0; k < 800; k++) begin
            if (exp_q.size() < DEPTH || exp_q.size() == DEPTH + 2) begin
                n_cmp++;
                if (wr_ready !== (exp_q.size() < DEPTH)) begin
                    n_err++; $display("FAIL rand_ready held=%0d wr_ready=%b", exp_q.size(), wr_ready);
                end
            end
            tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 2) == 0);
            if (last_pop) begin
                n_cmp++;
                if (last_data !== last_exp) begin
                    n_err++; $display("FAIL rand_data k=%0d got=%h want %h", k, last_data, last_exp);
                end
            end
            n_cmp++;
            if (level !== 8'(exp_q.size())) begin
                n_err++; $display("FAIL rand_level k=%0d got=%0d want %0d", k, level, exp_q.size());
            end
        end
        drain("rand");
    endtask

    task automatic test_flush;
        int n = 0;
        for (int c = 0; c < 50 && n < 10; c++) begin
            tick(1'b1, 8'(n + 100), 1'b0);
            if (last_acc) n++;
        end
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (last_pop !== 1'b1 || last_data !== last_exp) begin
            n_err++; $display("FAIL flush_prepop pop=%b data=%h want 1/%h", last_pop, last_data, last_exp);
        end
        flush = 1'b1;
        tick(1'b1, 8'h77, 1'b0);
        flush = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0 || level !== '0) begin
            n_err++; $display("FAIL flush_clear rd_valid=%b level=%0d want 0/0", rd_valid, level);
        end
        tick(1'b1, 8'h3C, 1'b0);
        for (int c = 0; c < 6 && rd_valid !== 1'b1; c++) tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C || level !== 8'd1) begin
            n_err++;
            $display("FAIL flush_first rd_valid=%b rd_data=%h level=%0d want 1/3c/1", rd_valid, rd_data, level);
        end
        drain("flush");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(i + 200), 1'b0);
        wr_valid = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0 || level !== '0 || rd_data !== '0 || ram_we_a !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid rd_valid=%b level=%0d rd_data=%h we_a=%b ovf=%b want 0/0/00/0/0",
                     rd_valid, level, rd_data, ram_we_a, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || level !== '0) begin
            n_err++; $display("FAIL rst_mid_idle wr_ready=%b rd_valid=%b level=%0d want 1/0/0", wr_ready, rd_valid, level);
        end
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
            n_err++; $display("FAIL rst_mid_reuse rd_valid=%b rd_data=%h want 1/5a", rd_valid, rd_data);
        end
        drain("rst_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
